// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole sequencer.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PICK = 3'd1,
        SHOW = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int         NUM_HOLES = 8;
    localparam logic [3:0] POS_NONE  = 4'd0;

    // Map a random value onto holes 1..NUM_HOLES, stepping past the previous hole
    // so two consecutive moles never share a hole.
    function automatic logic [3:0] pick_hole(input logic [7:0] rnd, input logic [3:0] prev);
        logic [3:0] cand;
        cand = {1'b0, rnd[2:0]} + 4'd1;
        if (cand == prev) begin
            cand = (cand == 4'(NUM_HOLES)) ? 4'd1 : cand + 4'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit free-running Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module mole_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign q        = lfsr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks holes, times show/gap windows on a shared
// tick, judges button presses and keeps score and round counts.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int         SHOW_TICKS = 50,
    parameter int         GAP_TICKS  = 10,
    parameter int         ROUNDS     = 20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] btn,
    output logic [3:0] mole_pos,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [7:0] round_cnt,
    output logic       busy,
    output logic       done
);

    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    state_t        state_reg, state_next;
    logic [3:0]    pos_reg, prev_pos_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    score_reg, round_reg;
    logic [3:0]    mole_pos_reg, mole_pos_next;
    logic          hit_reg, hit_next;
    logic          miss_reg, miss_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [7:0]    lfsr_q;
    logic [3:0]    cand;
    logic [2:0]    pos_idx;
    logic          correct_press;
    logic          show_timeout;
    logic          gap_over;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign cand          = pick_hole(lfsr_q, prev_pos_reg);
    assign pos_idx       = 3'(pos_reg - 4'd1);
    assign correct_press = (state_reg == SHOW) && btn[pos_idx];
    assign show_timeout  = tick && (timer_reg == TW'(SHOW_TICKS - 1));
    assign gap_over      = tick && (timer_reg == TW'(GAP_TICKS - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pos_reg      <= POS_NONE;
            prev_pos_reg <= POS_NONE;
            timer_reg    <= '0;
            score_reg    <= '0;
            round_reg    <= '0;
            mole_pos_reg <= POS_NONE;
            hit_reg      <= 1'b0;
            miss_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mole_pos_reg <= mole_pos_next;
            hit_reg      <= hit_next;
            miss_reg     <= miss_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        score_reg <= '0;
                        round_reg <= '0;
                    end
                end
                PICK: begin
                    pos_reg      <= cand;
                    prev_pos_reg <= cand;
                    timer_reg    <= '0;
                end
                SHOW: begin
                    if (correct_press || show_timeout) begin
                        // Leaving SHOW closes the round; round_reg never exceeds ROUNDS.
                        timer_reg <= '0;
                        round_reg <= round_reg + 8'd1;
                        if (correct_press && score_reg != 8'hFF) begin
                            score_reg <= score_reg + 8'd1;
                        end
                    end else if (tick) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                GAP: begin
                    if (tick) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = PICK;
            PICK:       state_next = SHOW;
            SHOW:       if (correct_press || show_timeout) state_next = GAP;
            GAP: begin
                if (gap_over) begin
                    state_next = (round_reg == 8'(ROUNDS)) ? DONE : PICK;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        mole_pos_next = POS_NONE;
        if (state_next == SHOW) begin
            mole_pos_next = (state_reg == PICK) ? cand : pos_reg;
        end
        hit_next  = correct_press;
        miss_next = (state_reg == SHOW) && show_timeout && !correct_press;
        busy_next = (state_next == PICK) || (state_next == SHOW) || (state_next == GAP);
        done_next = (state_next == DONE);
    end

    assign mole_pos  = mole_pos_reg;
    assign hit       = hit_reg;
    assign miss      = miss_reg;
    assign score     = score_reg;
    assign round_cnt = round_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: short 3-round game plus a 255-round endurance run.
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, start = 1'b0;
    logic [7:0] btn = 8'h00;
    logic [3:0] mole_pos;
    logic       hit, miss, busy, done;
    logic [7:0] score, round_cnt;

    logic       tick2 = 1'b1, start2 = 1'b0;
    logic [3:0] mole_pos2;
    logic       hit2, miss2, busy2, done2;
    logic [7:0] score2, round_cnt2;

    int checks = 0;
    int errors = 0;

    logic [7:0] lm;
    logic [3:0] prev_m;
    logic [3:0] exp_pos;
    int         misses, hits;

    always #5 clk = ~clk;

    mole_scheduler #(.SHOW_TICKS(4), .GAP_TICKS(2), .ROUNDS(3), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn),
        .mole_pos(mole_pos), .hit(hit), .miss(miss), .score(score),
        .round_cnt(round_cnt), .busy(busy), .done(done)
    );

    mole_scheduler #(.SHOW_TICKS(1), .GAP_TICKS(1), .ROUNDS(255), .LFSR_SEED(8'hA5)) dut2 (
        .clk(clk), .rst(rst), .tick(tick2), .start(start2), .btn(8'h00),
        .mole_pos(mole_pos2), .hit(hit2), .miss(miss2), .score(score2),
        .round_cnt(round_cnt2), .busy(busy2), .done(done2)
    );

    // Reference LFSR stepping alongside dut from the same reset.
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always @(posedge clk) begin
        if (rst) lm <= 8'hA5;
        else     lm <= lfsr_step(lm);
    end

    function automatic logic [3:0] expect_hole(input logic [7:0] r, input logic [3:0] prev);
        logic [3:0] c;
        c = 4'(r % 8) + 4'd1;
        if (c == prev) c = (c == 4'd8) ? 4'd1 : c + 4'd1;
        return c;
    endfunction

    function automatic logic [7:0] onehot(input logic [3:0] p);
        logic [7:0] one;
        one = 8'h01;
        return one << (p - 4'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected hole for the PICK edge that comes next.
    task automatic predict();
        exp_pos = expect_hole(lm, prev_m);
        prev_m  = exp_pos;
    endtask

    initial begin
        logic [3:0] last_mole, prev_sample;
        int         moles;

        // Reset values
        prev_m = 4'd0;
        repeat (3) step();
        check("rst_mole_pos", mole_pos, 0);
        check("rst_score", score, 0);
        check("rst_round_cnt", round_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit_miss", {hit, miss}, 0);
        rst = 1'b0;
        step();

        // Three unanswered rounds with tick every cycle
        misses = 0;
        hits   = 0;
        tick   = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int r = 0; r < 3; r++) begin
            predict();
            step();
            check("miss_game_pos", mole_pos, exp_pos);
            for (int k = 0; k < 6; k++) begin
                step();
                if (miss) misses++;
                if (hit) hits++;
            end
        end
        tick = 1'b0;
        check("miss_game_misses", misses, 3);
        check("miss_game_hits", hits, 0);
        check("miss_game_score", score, 0);
        check("miss_game_rounds", round_cnt, 3);
        check("miss_game_done", done, 1);
        check("miss_game_busy", busy, 0);
        check("miss_game_pos_dark", mole_pos, 0);

        // Restart from DONE; wrong press ignored, then correct press on the final tick
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        check("restart_score_clr", score, 0);
        check("restart_rounds_clr", round_cnt, 0);
        predict();
        step();
        check("latency_pos", mole_pos, exp_pos);
        btn = onehot((exp_pos == 4'd8) ? 4'd1 : exp_pos + 4'd1);
        step();
        btn = 8'h00;
        check("wrong_btn_no_hit", hit, 0);
        check("wrong_btn_mole_stays", mole_pos, exp_pos);
        tick = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        check("pre_timeout_no_miss", miss, 0);
        check("pre_timeout_pos", mole_pos, exp_pos);
        tick = 1'b1;
        btn  = onehot(exp_pos);
        step();
        tick = 1'b0;
        btn  = 8'h00;
        check("tie_hit", hit, 1);
        check("tie_no_miss", miss, 0);
        check("tie_score", score, 1);
        check("tie_gap_dark", mole_pos, 0);
        check("tie_round", round_cnt, 1);
        step();
        check("hit_one_cycle", hit, 0);

        // Gap, then a plain correct press without tick
        tick = 1'b1;
        repeat (2) step();
        tick = 1'b0;
        check("gap_to_pick_dark", mole_pos, 0);
        predict();
        step();
        check("round2_pos", mole_pos, exp_pos);
        btn = onehot(exp_pos);
        step();
        btn = 8'h00;
        check("round2_hit", hit, 1);
        check("round2_score", score, 2);
        check("round2_rounds", round_cnt, 2);

        // Round 3: start during SHOW ignored, then reset mid-SHOW
        tick = 1'b1;
        repeat (2) step();
        tick = 1'b0;
        predict();
        step();
        check("round3_pos", mole_pos, exp_pos);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_show_pos", mole_pos, exp_pos);
        check("start_in_show_rounds", round_cnt, 2);
        check("start_in_show_score", score, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        prev_m = 4'd0;
        check("midrst_pos", mole_pos, 0);
        check("midrst_score", score, 0);
        check("midrst_rounds", round_cnt, 0);
        check("midrst_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        predict();
        step();
        check("replay_pos", mole_pos, exp_pos);

        // 255-round endurance run on the second instance
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        last_mole   = 4'd0;
        prev_sample = 4'd0;
        moles       = 0;
        for (int cyc = 0; cyc < 2000 && !done2; cyc++) begin
            step();
            if (hit2 && miss2) check("hit_miss_exclusive", {hit2, miss2}, 2'b01);
            if (cyc == 2) begin
                start2 = 1'b1;
            end else begin
                start2 = 1'b0;
            end
            if (mole_pos2 != 4'd0 && prev_sample == 4'd0) begin
                moles++;
                check("long_pos_range", (mole_pos2 >= 4'd1 && mole_pos2 <= 4'd8), 1);
                check("long_pos_differs", (mole_pos2 != last_mole), 1);
                last_mole = mole_pos2;
            end
            prev_sample = mole_pos2;
        end
        start2 = 1'b0;
        check("long_done", done2, 1);
        check("long_moles", moles, 255);
        check("long_rounds", round_cnt2, 255);
        check("long_score", score2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
